// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the core's load/store port. It accepts one word
// request at a time over a req/ack handshake, waits WAIT_CYCLES clock cycles,
// performs the read or write on an internal word array, then returns a
// one-cycle acknowledge that carries the read data and an error flag. Only the
// single captured request is held; req is ignored while the responder is busy.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, 4..65536)
//   WAIT_CYCLES  wait states inserted before each access (0..15)
//
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous, active-high reset
//   req    in   1   request strobe, sampled only in IDLE
//   we     in   1   1 = write, 0 = read, captured with req
//   addr   in   32  byte address, captured with req
//   wdata  in   32  write data, captured with req
//   busy   out  1   high whenever the FSM is not in IDLE
//   ack    out  1   one-cycle response pulse
//   rdata  out  32  read data, valid while ack is high; holds its last value
//   err    out  1   access error flag, valid while ack is high
//
// Build option
//   DATA_MEM_RESP_ALIGN_CHECK_EN  when defined, a captured addr with
//   addr[1:0] != 0 answers with err=1 and rdata=0, and no write is performed.
//   When undefined, addr[1:0] is ignored and err is always 0.
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // -------------------------------------------------------------------------
    // State and request registers
    // -------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [3:0]       r_count;

    logic             r_we;
    logic [IDX_W-1:0] r_index;
    logic [31:0]      r_wdata;

    logic             r_ack;
    logic             r_err;
    logic [31:0]      r_rdata;

    logic [31:0]      r_mem [DEPTH];

    logic             w_capture;
    logic             w_access;
    logic             w_do_write;
    logic             w_misaligned;

    // Address bits above the array window wrap away; the low byte-offset bits
    // only matter when the alignment check is built in.
    logic             w_unused_addr;
    assign w_unused_addr = ^{addr[31:IDX_W+2], addr[1:0]};

    // A request is taken only from IDLE; anything arriving later is dropped.
    assign w_capture = (r_state == S_IDLE) && req;

    // The access happens on the edge that leaves WAIT with the counter spent.
    assign w_access  = (r_state == S_WAIT) && (r_count == 4'd0);

    // -------------------------------------------------------------------------
    // Optional alignment check
    // -------------------------------------------------------------------------
`ifdef DATA_MEM_RESP_ALIGN_CHECK_EN
    logic r_misaligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_misaligned <= 1'b0;
        end else if (w_capture) begin
            r_misaligned <= |addr[1:0];
        end
    end

    assign w_misaligned = r_misaligned;
`else
    assign w_misaligned = 1'b0;
`endif

    // A write that is still waiting when reset arrives is discarded, so the
    // array update is gated with reset even though the array itself is not
    // cleared.
    assign w_do_write = !reset && w_access && r_we && !w_misaligned;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req)              w_state_nxt = S_WAIT;
            S_WAIT:  if (r_count == 4'd0)  w_state_nxt = S_RESP;
            S_RESP:                        w_state_nxt = S_IDLE;
            default:                       w_state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM, wait counter and registered response
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= 4'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;

            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_count <= WAIT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end
                end
                default: ;
            endcase

            if (w_access) begin
                r_ack <= 1'b1;
                r_err <= w_misaligned;
                if (w_misaligned) begin
                    r_rdata <= 32'd0;
                end else if (!r_we) begin
                    r_rdata <= r_mem[r_index];
                end
            end else if (r_state == S_RESP) begin
                r_ack <= 1'b0;
                r_err <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Captured request. Only meaningful while busy, so no reset is needed.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_capture && !reset) begin
            r_we    <= we;
            r_index <= addr[IDX_W+1:2];
            r_wdata <= wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    // NOTE: the array is deliberately left out of reset; contents survive a
    // reset and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[r_index] <= r_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy  = (r_state != S_IDLE);
    assign ack   = r_ack;
    assign err   = r_err;
    assign rdata = r_rdata;

endmodule
